gate_net_infer_ctrl: RTL and testbench
======================================

GATE_NET_INFER_CTRL -- requirements
Module: gate_net_infer_ctrl

Interface
REQ-001 SHALL have parameter IN_W, default 98, meaning the width of the feature vector driven into the classifier network.
REQ-002 SHALL have parameter OUT_W, default 2, meaning the width of the classifier network output.
REQ-003 SHALL have parameter SETTLE, default 2, range 1..15, meaning the cycles allowed for the network output to settle after the input is loaded.
REQ-004 SHALL have parameter CNT_W, default 16, meaning the width of each statistics counter.
REQ-005 SHALL provide the following ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  sample offered.
- in_ready  out  1  controller can accept a sample.
- in_data  in  IN_W  feature bits.
- net_in  out  IN_W  registered drive to the network in_bits.
- net_out  in  OUT_W  network out_bits.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_bits  out  OUT_W  captured raw network output.
- res_class  out  1  decoded class.
- res_tie  out  1  decode ambiguous.
- busy  out  1  high in any state other than IDLE.
- stats_clr  in  1  clear the statistics counters.
- cnt_c0, cnt_c1, cnt_tie  out  CNT_W each  per-outcome counters.

Function
REQ-006 SHALL implement FSM states IDLE, SETTLE, HOLD.
REQ-007 SHALL assert in_ready only in IDLE.
REQ-008 Accept occurs on an edge where in_valid and in_ready are both high: SHALL register net_in<=in_data, load settle counter<=SETTLE, and go to SETTLE.
REQ-009 In SETTLE, SHALL decrement the counter each cycle; on the edge where the counter equals 1, SHALL capture res_bits<=net_out, decode, and go to HOLD.
REQ-010 SHALL raise res_valid exactly SETTLE cycles after the accept edge, and SHALL hold it high only in HOLD.
REQ-011 SHALL leave net_in unchanged from accept until the next accept.
REQ-012 Decode: if net_out[1]!=net_out[0], SHALL set res_class=net_out[1] and res_tie=0; otherwise SHALL set res_class=0 and res_tie=1.
REQ-013 For OUT_W>2, decode SHALL use bits [1:0] only; res_bits SHALL still carry all OUT_W bits.
REQ-014 In HOLD, res_bits, res_class and res_tie SHALL be stable until an edge where res_valid and res_ready are both high, after which the FSM SHALL return to IDLE.
REQ-015 SHALL NOT combinationally bypass from res_ready to in_ready; a new accept is possible at the earliest one cycle after result handoff, so throughput is at most 1 sample per SETTLE+2 cycles.
REQ-016 in_valid while busy SHALL be ignored; in_data SHALL NOT be sampled.
REQ-017 On handoff, SHALL increment exactly one of cnt_c0 (class 0, no tie), cnt_c1 or cnt_tie.
REQ-018 Counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-019 stats_clr SHALL zero all counters on the next edge; if stats_clr coincides with a handoff, clear SHALL win and the result SHALL NOT be counted.
REQ-020 busy SHALL equal (state!=IDLE).

Reset
REQ-021 When rst=1 at an edge, SHALL go to IDLE, and SHALL set net_in, res_bits, res_class, res_tie, res_valid and all counters to 0.
REQ-022 rst SHALL override every other input, including reset mid-SETTLE or mid-HOLD; a pending result SHALL be discarded and not counted.
REQ-023 in_ready SHALL be high in the first cycle after reset deasserts.

Configuration
REQ-024 Macro INFER_STATS_EN: when defined, SHALL implement the counters and stats_clr per REQ-017..REQ-019.
REQ-025 When INFER_STATS_EN is not defined, SHALL keep all ports, SHALL tie cnt_c0, cnt_c1 and cnt_tie to 0, SHALL ignore stats_clr, and SHALL leave all other behaviour identical.

Verification
REQ-026 Config SETTLE=2: accept in_data with bit0=1 at edge E0, net_out=2'b10 -> res_valid=1 after E2, res_class=1, res_tie=0, res_bits=2'b10.
REQ-027 net_out=2'b11, then a separate sample with net_out=2'b00 -> res_tie=1 and res_class=0 both times; cnt_tie=2 (macro defined).
REQ-028 Hold res_ready=0 for 10 cycles while toggling net_out -> res_bits unchanged, in_ready=0, second in_valid ignored; res_ready=1 -> IDLE next cycle, net_in still equals the first sample.
REQ-029 Assert rst mid-SETTLE -> next cycle: state IDLE, res_valid=0, net_in=0, counters unchanged-at-0, no count recorded.
REQ-030 Config CNT_W=4: run 17 class-1 results -> cnt_c1=15; stats_clr together with an 18th handoff -> all counters 0.
REQ-031 Compile without INFER_STATS_EN: repeat REQ-026 -> identical result timing; cnt_* stay 0.

Source files
------------

// File: rtl/gate_net_infer_ctrl.sv
// Sequencing controller for a combinational classifier network: accept, settle, capture/decode, hold.
// Optional outcome statistics are built only when INFER_STATS_EN is defined.
module gate_net_infer_ctrl #(
  parameter int IN_W   = 98,
  parameter int OUT_W  = 2,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic [IN_W-1:0]  net_in,
  input  logic [OUT_W-1:0] net_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OUT_W-1:0] res_bits,
  output logic             res_class,
  output logic             res_tie,
  output logic             busy,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] cnt_c0,
  output logic [CNT_W-1:0] cnt_c1,
  output logic [CNT_W-1:0] cnt_tie
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  state_t     state;
  logic [3:0] settle_cnt;
  logic       handoff;

  // Status flags are pure decodes of the state register, so no input reaches them combinationally.
  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign handoff  = (state == ST_HOLD) && res_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      net_in     <= '0;
      res_bits   <= '0;
      res_class  <= 1'b0;
      res_tie    <= 1'b0;
      res_valid  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            net_in     <= in_data;
            settle_cnt <= SETTLE_LD;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt == 4'd1) begin
            res_bits  <= net_out;
            // Only the two low output bits vote; equal votes are ambiguous.
            res_class <= (net_out[1] != net_out[0]) ? net_out[1] : 1'b0;
            res_tie   <= (net_out[1] == net_out[0]);
            res_valid <= 1'b1;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef INFER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      cnt_c0  <= '0;
      cnt_c1  <= '0;
      cnt_tie <= '0;
    end else if (handoff) begin
      if (res_tie) begin
        if (cnt_tie != '1) cnt_tie <= cnt_tie + 1'b1;
      end else if (res_class) begin
        if (cnt_c1 != '1) cnt_c1 <= cnt_c1 + 1'b1;
      end else begin
        if (cnt_c0 != '1) cnt_c0 <= cnt_c0 + 1'b1;
      end
    end
  end
`else
  logic unused_stats;
  assign unused_stats = stats_clr ^ handoff;
  assign cnt_c0  = '0;
  assign cnt_c1  = '0;
  assign cnt_tie = '0;
`endif

endmodule

// File: tb/tb_gate_net_infer_ctrl.sv
// Directed self-checking bench for gate_net_infer_ctrl (SETTLE=2, CNT_W=4 to reach saturation quickly).
module tb_gate_net_infer_ctrl;

  localparam int IN_W   = 98;
  localparam int OUT_W  = 2;
  localparam int SETTLE = 2;
  localparam int CNT_W  = 4;
`ifdef INFER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [IN_W-1:0]  net_in;
  logic [OUT_W-1:0] net_out;
  logic             res_valid;
  logic             res_ready;
  logic [OUT_W-1:0] res_bits;
  logic             res_class;
  logic             res_tie;
  logic             busy;
  logic             stats_clr;
  logic [CNT_W-1:0] cnt_c0;
  logic [CNT_W-1:0] cnt_c1;
  logic [CNT_W-1:0] cnt_tie;

  int n_vec = 0;
  int n_bad = 0;

  gate_net_infer_ctrl #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .net_in(net_in), .net_out(net_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_bits(res_bits), .res_class(res_class), .res_tie(res_tie),
    .busy(busy), .stats_clr(stats_clr),
    .cnt_c0(cnt_c0), .cnt_c1(cnt_c1), .cnt_tie(cnt_tie)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CNT_W-1:0] ec(input int v);
    return STATS ? CNT_W'(v) : '0;
  endfunction

  task automatic check_cnts(input string tag, input int c0, input int c1, input int ct);
    check({tag, ".c0"},  cnt_c0,  ec(c0));
    check({tag, ".c1"},  cnt_c1,  ec(c1));
    check({tag, ".tie"}, cnt_tie, ec(ct));
  endtask

  // Accept, wait for the result, check latency and decode, then hand it off.
  task automatic do_sample(input string tag, input logic [IN_W-1:0] d, input logic [1:0] nout,
                           input logic exp_cls, input logic exp_tie, input logic clr);
    int n;
    check({tag, ".rdy"}, in_ready, 1'b1);
    in_data  = d;
    net_out  = nout;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, ".net_in"}, net_in, d);
    n = 0;
    while (!res_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, ".lat"}, n, SETTLE);
    check({tag, ".bits"}, res_bits, nout);
    check({tag, ".cls"}, res_class, exp_cls);
    check({tag, ".tie"}, res_tie, exp_tie);
    res_ready = 1'b1;
    stats_clr = clr;
    step();
    res_ready = 1'b0;
    stats_clr = 1'b0;
    check({tag, ".done_v"}, res_valid, 1'b0);
    check({tag, ".done_r"}, in_ready, 1'b1);
  endtask

  logic [IN_W-1:0] d_a, d_b, d_c;

  initial begin
    d_a = {2'b10, 32'hCAFE_F00D, 64'h0123_4567_89AB_CDEF};
    d_b = {2'b01, 32'h1357_9BDF, 64'hFEDC_BA98_7654_3210};
    d_c = {2'b11, 32'h0F0F_0F0F, 64'hA5A5_A5A5_5A5A_5A5B};
    rst = 1'b1; in_valid = 1'b0; in_data = '0; net_out = '0;
    res_ready = 1'b0; stats_clr = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    check("rst.in_ready", in_ready, 1'b1);
    check("rst.busy", busy, 1'b0);
    check("rst.res_valid", res_valid, 1'b0);
    check("rst.net_in", net_in, '0);
    check("rst.res_bits", res_bits, '0);
    check_cnts("rst", 0, 0, 0);

    // Class 1 with explicit cycle-by-cycle timing
    in_data = d_a; net_out = 2'b10; in_valid = 1'b1;
    step();                                   // E0
    in_valid = 1'b0;
    check("c1.busy", busy, 1'b1);
    check("c1.in_ready", in_ready, 1'b0);
    check("c1.v_e0", res_valid, 1'b0);
    step();                                   // E1
    check("c1.v_e1", res_valid, 1'b0);
    step();                                   // E2
    check("c1.v_e2", res_valid, 1'b1);
    check("c1.cls", res_class, 1'b1);
    check("c1.tie", res_tie, 1'b0);
    check("c1.bits", res_bits, 2'b10);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("c1.idle", in_ready, 1'b1);
    check_cnts("c1", 0, 1, 0);

    // Ties both ways
    do_sample("tie11", d_b, 2'b11, 1'b0, 1'b1, 1'b0);
    do_sample("tie00", d_c, 2'b00, 1'b0, 1'b1, 1'b0);
    check_cnts("ties", 0, 1, 2);

    // Backpressure: result stays frozen, new offers ignored
    in_data = d_a; net_out = 2'b01; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    check("bp.v", res_valid, 1'b1);
    check("bp.cls", res_class, 1'b0);
    check("bp.tie", res_tie, 1'b0);
    in_data = d_b; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      net_out = 2'(i);
      step();
      check("bp.bits", res_bits, 2'b01);
      check("bp.rdy", in_ready, 1'b0);
      check("bp.net_in", net_in, d_a);
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("bp.rel_rdy", in_ready, 1'b1);
    check("bp.rel_v", res_valid, 1'b0);
    check("bp.rel_net_in", net_in, d_a);
    check_cnts("bp", 1, 1, 2);

    // Reset mid-SETTLE
    in_data = d_c; net_out = 2'b10; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rs.rdy", in_ready, 1'b1);
    check("rs.v", res_valid, 1'b0);
    check("rs.net_in", net_in, '0);
    check_cnts("rs", 0, 0, 0);

    // Reset mid-HOLD with res_ready high: the pending result must not be counted
    in_data = d_b; net_out = 2'b10; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    check("rh.v", res_valid, 1'b1);
    rst = 1'b1; res_ready = 1'b1;
    step();
    rst = 1'b0; res_ready = 1'b0;
    check("rh.v0", res_valid, 1'b0);
    check("rh.busy", busy, 1'b0);
    check_cnts("rh", 0, 0, 0);

    // Saturation at 15 with CNT_W=4, then clear coinciding with a handoff
    do_sample("sat_t", d_c, 2'b00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) begin
      do_sample("sat", d_a, 2'b10, 1'b1, 1'b0, 1'b0);
      if (i == 13) check("sat.c1_14", cnt_c1, ec(14));
    end
    check_cnts("sat", 0, 15, 1);
    do_sample("clr", d_a, 2'b10, 1'b1, 1'b0, 1'b1);
    check_cnts("clr", 0, 0, 0);
    do_sample("post", d_b, 2'b01, 1'b0, 1'b0, 1'b0);
    check_cnts("post", 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
